// File: rtl/accum_pkg.sv
// Shared types and default sizing for the accumulator slice.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } accum_state_t;

  localparam int ACCUM_NUM_BITS  = 4;
  localparam int ACCUM_NUM_TERMS = 4;

endpackage

// File: rtl/adder_nbit.sv
// Unsigned ripple adder: {overflow, sum} = a + b + carry_in.
module adder_nbit #(
  parameter int NUM_BITS = 4
) (
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow
);

  // Full-width add; the extra bit is the carry-out.
  always_comb begin
    {overflow, sum} = {1'b0, a} + {1'b0, b} + {{NUM_BITS{1'b0}}, carry_in};
  end

endmodule

// File: rtl/accumulator_nbit.sv
// Streaming accumulator: sums NUM_TERMS operands through adder_nbit and
// presents the total plus a sticky carry flag on an output handshake.
// Optional build macro: ACCUM_SATURATE_EN (clamp the sum to all ones on carry).
//
// state | meaning
// IDLE  | waiting for start; no handshakes
// ACCUM | accepting operands, one per cycle
// DONE  | result held until out_ready
import accum_pkg::*;

module accumulator_nbit #(
  parameter int NUM_BITS  = ACCUM_NUM_BITS,
  parameter int NUM_TERMS = ACCUM_NUM_TERMS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] result,
  output logic                overflow,
  output logic                busy
);

  localparam int CW = $clog2(NUM_TERMS + 1);

  accum_state_t        state, state_nxt;
  logic [NUM_BITS-1:0] acc, acc_nxt;
  logic [CW-1:0]       count, count_nxt;
  logic                ovf, ovf_nxt;
  logic [NUM_BITS-1:0] add_sum;
  logic                add_carry;
  logic                take;

  adder_nbit #(.NUM_BITS(NUM_BITS)) u_adder (
    .a        (acc),
    .b        (in_data),
    .carry_in (1'b0),
    .sum      (add_sum),
    .overflow (add_carry)
  );

  // Handshake and status outputs depend on state only; result and flag are
  // masked outside DONE so nothing partial is ever visible.
  assign take      = in_valid && (state == ACCUM);
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = (state == DONE) ? acc : '0;
  assign overflow  = (state == DONE) ? ovf : 1'b0;

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = '0;
          count_nxt = '0;
          ovf_nxt   = 1'b0;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (take) begin
`ifdef ACCUM_SATURATE_EN
          acc_nxt = add_carry ? {NUM_BITS{1'b1}} : add_sum;
`else
          acc_nxt = add_sum;
`endif
          ovf_nxt   = ovf | add_carry;
          count_nxt = count + CW'(1);
          if (count == CW'(NUM_TERMS - 1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_accumulator_nbit.sv
// Directed self-checking bench for accumulator_nbit (NUM_BITS=4, NUM_TERMS=4).
module tb_accumulator_nbit;

  typedef struct packed {
    logic [3:0] res;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] result;
  logic       overflow;
  logic       busy;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  accumulator_nbit #(.NUM_BITS(4), .NUM_TERMS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_result"}, 32'(result), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
  endtask

  // Runs one accumulation of four operands with `gap` idle cycles between
  // operands, then holds DONE for `hold` cycles (pulsing start) before release.
  task automatic accum(input string tag, input logic [15:0] ops, input int gap, input int hold);
    logic [3:0] m_acc;
    logic       m_ovf;
    logic [4:0] tmp;
    exp_t       e;
    int         n;
    m_acc = '0;
    m_ovf = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_c1"}, 32'(busy), 1);
    chk({tag, "_in_ready_c1"}, 32'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          tick();
          chk({tag, "_gap_in_ready"}, 32'(in_ready), 1);
          chk({tag, "_gap_out_valid"}, 32'(out_valid), 0);
        end
      end
      chk({tag, "_pre_out_valid"}, 32'(out_valid), 0);
      in_valid = 1'b1;
      in_data  = ops[4*i +: 4];
      tmp   = {1'b0, m_acc} + {1'b0, in_data};
      m_ovf = m_ovf | tmp[4];
`ifdef ACCUM_SATURATE_EN
      m_acc = tmp[4] ? 4'hF : tmp[3:0];
`else
      m_acc = tmp[3:0];
`endif
      tick();
    end
    in_valid = 1'b0;
    exp_q.push_back('{res: m_acc, ovf: m_ovf});
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_out_valid_latency"}, 32'(n), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 1);
    chk({tag, "_in_ready_done"}, 32'(in_ready), 0);
    e = exp_q.pop_front();
    chk({tag, "_result"}, 32'(result), 32'(e.res));
    chk({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
    for (int h = 0; h < hold; h++) begin
      start = (h == 1);
      tick();
      chk({tag, "_hold_out_valid"}, 32'(out_valid), 1);
      chk({tag, "_hold_result"}, 32'(result), 32'(e.res));
      chk({tag, "_hold_overflow"}, 32'(overflow), 32'(e.ovf));
    end
    out_ready = 1'b1;
    start     = (hold > 0);
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk_idle({tag, "_after"});
    tick();
    chk({tag, "_stays_idle"}, 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    accum("seq1234", {4'd4, 4'd3, 4'd2, 4'd1}, 0, 0);
    accum("wrap8800", {4'd0, 4'd0, 4'd8, 4'd8}, 0, 0);
    accum("all15", {4'd15, 4'd15, 4'd15, 4'd15}, 0, 0);
    accum("gap3", {4'd4, 4'd3, 4'd2, 4'd1}, 3, 0);
    accum("hold5", {4'd6, 4'd5, 4'd1, 4'd7}, 0, 5);

    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'd5;
    tick();
    in_data  = 4'd6;
    tick();
    in_valid = 1'b0;
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("mid_reset");
    tick();
    chk_idle("mid_reset_next");

    accum("after_rst", {4'd2, 4'd2, 4'd2, 4'd2}, 0, 0);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/accumulator_nbit.md
# accumulator_nbit

Sequential accumulator directly downstream of `adder_nbit`. It accepts a stream of `NUM_TERMS` unsigned operands over a valid/ready handshake and adds each one into a registered running sum. The addition is done by an `adder_nbit` instance whose `a` input is fed back from the accumulator register. When the last operand is accepted it presents the final sum and a sticky overflow flag on an output handshake.

## Interface
- `NUM_BITS`, default 4: operand and result width in bits.
- `NUM_TERMS`, default 4: number of operands per accumulation; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin an accumulation; honoured only in IDLE.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  NUM_BITS  unsigned operand.
- `in_ready`  out  1  block accepts an operand this cycle.
- `out_valid`  out  1  `result` and `overflow` are valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  NUM_BITS  accumulated sum.
- `overflow`  out  1  sticky: at least one addition produced a carry-out.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - `in_ready`=0, `out_valid`=0.
  - `start`=1 clears `acc`, `count` and `overflow` to 0 and moves to ACCUM.
- ACCUM:
  - `in_ready`=1.
  - Each cycle with `in_valid` && `in_ready`: `acc` ← low NUM_BITS of {carry, sum} = `acc` + `in_data` with `carry_in`=0; `overflow` ← `overflow` | carry; `count`++.
  - The handshake that makes the accepted-operand count reach NUM_TERMS moves the FSM to DONE.
  - Cycles without `in_valid` change nothing.
- DONE:
  - `out_valid`=1; `result`=`acc`.
  - Both outputs are held stable until `out_ready`=1, then the FSM goes to IDLE.
- `start` is ignored in ACCUM and DONE, including DONE with `out_ready`=1 in the same cycle.
- `count` width is $clog2(NUM_TERMS+1). Arithmetic is unsigned; by default the sum wraps modulo 2^NUM_BITS.
- Reset mid-operation abandons the accumulation. No partial result is ever presented.

## Timing
- Reset values: state=IDLE; `acc`=0, `count`=0, `overflow`=0. Outputs `in_ready`, `out_valid`, `result`, `overflow` and `busy` all read 0.
- `in_ready`, `out_valid` and `busy` are decoded from state only. There is no combinational path from `in_valid` or `out_ready` to them.
- `start` sampled at edge 0 → ACCUM from cycle 1. With `in_valid` held high, operands are accepted in cycles 1..NUM_TERMS, and `out_valid` rises in cycle NUM_TERMS+1.
- Throughput: one operand per cycle. The `adder_nbit` path is combinational within a single cycle.
- Result → IDLE: one cycle after `out_ready` is sampled high. The next `start` is accepted in that IDLE cycle at the earliest.

## Configuration
- `ACCUM_SATURATE_EN` defined: any addition that produces a carry sets `acc` to all ones (2^NUM_BITS−1), and `overflow` is still set. `acc` stays at all ones for the rest of the accumulation.
- `ACCUM_SATURATE_EN` undefined: `acc` wraps modulo 2^NUM_BITS. `overflow` behaves the same in both builds.

## Structure
- Package `accum_pkg`:
  - `accum_state_t` enum {IDLE, ACCUM, DONE}.
  - Default constants `ACCUM_NUM_BITS`=4 and `ACCUM_NUM_TERMS`=4.
- One sub-module, `adder_nbit`:
  - `a`=`acc`, `b`=`in_data`, `carry_in`=1'b0.
  - `sum` drives the next `acc`; `overflow` is the carry.
- Register logic and next-state logic are kept in separate processes.

## Test plan
All scenarios use NUM_BITS=4, NUM_TERMS=4.
- `start`, then 1,2,3,4 back-to-back, `out_ready`=1 → `out_valid` in cycle 5, `result`=10, `overflow`=0, `busy` falls in cycle 6.
- Operands 8,8,0,0 → `result`=0, `overflow`=1. With `ACCUM_SATURATE_EN`: `result`=15, `overflow`=1.
- Operands 15,15,15,15 → `result`=12, `overflow`=1. With `ACCUM_SATURATE_EN`: `result`=15.
- 1,2,3,4 with 3 idle `in_valid` cycles between operands → `result`=10; `in_ready` stays high throughout; `count` advances only on handshakes.
- In DONE, `out_ready` held low 5 cycles with `start` pulsed → `result` and `out_valid` stable, `start` ignored; `out_ready`=1 → IDLE next cycle.
- `rst` after 2 operands → next cycle all outputs 0 and state IDLE. A fresh `start` with 2,2,2,2 → `result`=8, `overflow`=0.
